// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared parameter defaults and FSM state encoding for the
// data-memory arbiter (dmem_arbiter and its counters).
package dmem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_MAX_WAIT  = 8;
    localparam int unsigned DEF_BURST_LEN = 4;

    // S_CORE: core has priority; S_FORCE: bounded loader burst after starvation.
    typedef enum logic {
        S_CORE  = 1'b0,
        S_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: saturating up-counter with synchronous clear and a
// terminal-compare flag.
//   clk, rst  : clock, asynchronous active-high reset
//   inc       : count up by one this cycle (saturates at TERM)
//   clr       : clear to zero this cycle (wins over inc)
//   last_c    : combinational, high while the count is TERM-1, i.e. the next
//               increment reaches the terminal value
module arb_sat_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned TERM  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic last_c
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear dominates, increment saturates at TERM.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != WIDTH'(TERM))) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_c = (count_q == WIDTH'(TERM - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline
// memory stage (core) and a loader/DMA requester. The core wins by default;
// once the loader has been denied MAX_WAIT consecutive cycles, a loader burst
// of up to BURST_LEN beats is forced, stalling the core.
//   core_*  : core request (req/we/addr/wdata), rdata pass-through, stall
//   ld_*    : loader request (req/we/addr/wdata), grant, registered rdata/rvalid
//   mem_*   : memory write-enable, address, write data, combinational read data
// Grant, stall and memory controls are combinational from the current state.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [DATA_W-1:0] ld_rdata_q;
    logic [DATA_W-1:0] ld_rdata_d;
    logic              ld_rvalid_q;
    logic              ld_rvalid_d;

    logic wait_inc;
    logic wait_clr;
    logic wait_last;
    logic beat_inc;
    logic beat_clr;
    logic beat_last;

    // Consecutive denied loader cycles while the core has priority.
    arb_sat_counter #(
        .WIDTH (WAIT_W),
        .TERM  (MAX_WAIT)
    ) wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (wait_inc),
        .clr    (wait_clr),
        .last_c (wait_last)
    );

    // Loader beats granted in the current forced burst.
    arb_sat_counter #(
        .WIDTH (BEAT_W),
        .TERM  (BURST_LEN)
    ) beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (beat_inc),
        .clr    (beat_clr),
        .last_c (beat_last)
    );

    // Ownership, stall, counter control and next state.
    always_comb begin
        state_d    = state_q;
        ld_gnt     = 1'b0;
        core_stall = 1'b0;
        wait_inc   = 1'b0;
        wait_clr   = 1'b0;
        beat_inc   = 1'b0;
        beat_clr   = 1'b0;
        unique case (state_q)
            S_CORE: begin
                ld_gnt   = ld_req & ~core_req;
                wait_inc = ld_req & core_req;
                // Cleared on a grant or when the loader is idle.
                wait_clr = ~wait_inc;
                if (wait_inc && wait_last) begin
                    state_d  = S_FORCE;
                    wait_clr = 1'b1;
                end
            end
            S_FORCE: begin
                ld_gnt     = ld_req;
                core_stall = ld_req & core_req;
                wait_clr   = 1'b1;
                beat_inc   = ld_req;
                // Burst ends on its last beat or as soon as the loader goes idle.
                if (!ld_req || beat_last) begin
                    state_d  = S_CORE;
                    beat_clr = 1'b1;
                end
            end
            default: begin
                state_d = S_CORE;
            end
        endcase
    end

    // Memory port mux: the core drives the port whenever the loader is not granted.
    assign mem_addr   = ld_gnt ? ld_addr  : core_addr;
    assign mem_wdata  = ld_gnt ? ld_wdata : core_wdata;
    assign mem_we     = ld_gnt ? ld_we    : (core_req & core_we);
    assign core_rdata = mem_rdata;

    // Loader read return path, one cycle after the grant.
    always_comb begin
        ld_rdata_d  = ld_rdata_q;
        ld_rvalid_d = ld_gnt & ~ld_we;
        if (ld_gnt && !ld_we) begin
            ld_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_CORE;
            ld_rdata_q  <= '0;
            ld_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_rdata_q  <= ld_rdata_d;
            ld_rvalid_q <= ld_rvalid_d;
        end
    end

    assign ld_rdata  = ld_rdata_q;
    assign ld_rvalid = ld_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a small word
// memory, directed scenarios and a randomized run against a reference model.
module tb_dmem_arbiter;

    localparam int unsigned MAX_WAIT  = 8;
    localparam int unsigned BURST_LEN = 4;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic [31:0] ld_rdata;
    logic        ld_rvalid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Physical memory driven by the DUT, and the bench's own expected copy.
    logic [31:0] tb_mem [0:255] = '{default: '0};
    logic [31:0] m_mem  [0:255] = '{default: '0};

    // Reference model state.
    bit          m_burst;
    int          m_denied;
    int          m_beats;
    bit          m_rvalid;
    logic [31:0] m_rdata;

    function automatic int unsigned widx(input logic [31:0] a);
        return int'((a >> 2) & 32'hFF);
    endfunction

    dmem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MAX_WAIT  (MAX_WAIT),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_gnt     (ld_gnt),
        .ld_rdata   (ld_rdata),
        .ld_rvalid  (ld_rvalid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[widx(mem_addr)];
    always @(posedge clk) begin
        if (mem_we) tb_mem[widx(mem_addr)] <= mem_wdata;
    end

    task automatic set_core(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        core_req = r; core_we = w; core_addr = a; core_wdata = d;
    endtask

    task automatic set_ld(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        ld_req = r; ld_we = w; ld_addr = a; ld_wdata = d;
    endtask

    task automatic model_reset();
        m_burst = 0; m_denied = 0; m_beats = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_core(0, 0, 32'h0, 32'h0);
        set_ld(0, 0, 32'h0, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        set_core(1, 0, 32'h40, 32'h0);
        set_ld(1, 0, 32'h44, 32'h0);
        #1;
        n_tests++;
        if (core_stall !== 1'b0 || ld_gnt !== 1'b0) begin
            n_fail++; $display("FAIL reset_both_req: stall=%b gnt=%b expected 0 0", core_stall, ld_gnt);
        end
        n_tests++;
        if (ld_rvalid !== 1'b0 || ld_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_ld_regs: rvalid=%b rdata=%h expected 0 0", ld_rvalid, ld_rdata);
        end
        core_req = 1'b0;
        #1;
        n_tests++;
        if (ld_gnt !== 1'b1 || mem_addr !== 32'h44) begin
            n_fail++; $display("FAIL reset_comb_follow: gnt=%b addr=%h expected 1 00000044", ld_gnt, mem_addr);
        end
        ld_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_core_only();
        do_reset();
        @(negedge clk);
        set_core(1, 1, 32'h10, 32'hDEADBEEF);
        #1;
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF || core_stall !== 1'b0) begin
            n_fail++; $display("FAIL core_store: we=%b addr=%h wdata=%h stall=%b expected 1 00000010 deadbeef 0",
                               mem_we, mem_addr, mem_wdata, core_stall);
        end
        m_mem[widx(32'h10)] = 32'hDEADBEEF;
        @(negedge clk);
        set_core(1, 0, 32'h10, 32'h0);
        #1;
        n_tests++;
        if (core_rdata !== 32'hDEADBEEF || mem_we !== 1'b0 || core_stall !== 1'b0) begin
            n_fail++; $display("FAIL core_load: rdata=%h we=%b stall=%b expected deadbeef 0 0",
                               core_rdata, mem_we, core_stall);
        end
    endtask

    task automatic test_loader_idle();
        do_reset();
        @(negedge clk);
        set_ld(1, 0, 32'h10, 32'h0);
        #1;
        n_tests++;
        if (ld_gnt !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL ld_idle_gnt: gnt=%b addr=%h we=%b expected 1 00000010 0", ld_gnt, mem_addr, mem_we);
        end
        @(negedge clk);
        set_ld(0, 0, 32'h0, 32'h0);
        #1;
        n_tests++;
        if (ld_rvalid !== 1'b1 || ld_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL ld_idle_rdata: rvalid=%b rdata=%h expected 1 deadbeef", ld_rvalid, ld_rdata);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (ld_rvalid !== 1'b0 || ld_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL ld_idle_hold: rvalid=%b rdata=%h expected 0 deadbeef", ld_rvalid, ld_rdata);
        end
    endtask

    // Both sides request every cycle: 8 denied, 4 forced, repeating every 12.
    task automatic test_starvation();
        bit exp_g;
        bit exp_v;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            set_core(1, 0, 32'h20, 32'h0);
            set_ld(1, 0, 32'h10, 32'h0);
            #1;
            exp_g = (c % 12) >= 8;
            exp_v = (c > 0) && (((c - 1) % 12) >= 8);
            n_tests++;
            if (ld_gnt !== exp_g || core_stall !== exp_g) begin
                n_fail++; $display("FAIL starve_c%0d: gnt=%b stall=%b expected %b %b", c, ld_gnt, core_stall, exp_g, exp_g);
            end
            n_tests++;
            if (mem_addr !== (exp_g ? 32'h10 : 32'h20) || ld_rvalid !== exp_v) begin
                n_fail++; $display("FAIL starve_mux_c%0d: addr=%h rvalid=%b expected %h %b",
                                   c, mem_addr, ld_rvalid, exp_g ? 32'h10 : 32'h20, exp_v);
            end
            if (c == 12) begin
                n_tests++;
                if (ld_rdata !== 32'hDEADBEEF) begin
                    n_fail++; $display("FAIL starve_rdata: rdata=%h expected deadbeef", ld_rdata);
                end
            end
        end
    endtask

    // Loader drops its request in the second forced cycle, then asks again.
    task automatic test_early_end();
        bit exp_g;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            set_core(1, 0, 32'h20, 32'h0);
            set_ld(c != 9, 0, 32'h10, 32'h0);
            #1;
            exp_g = (c == 8) || (c >= 18);
            n_tests++;
            if (ld_gnt !== exp_g || core_stall !== exp_g) begin
                n_fail++; $display("FAIL early_c%0d: gnt=%b stall=%b expected %b %b", c, ld_gnt, core_stall, exp_g, exp_g);
            end
            if (c == 9) begin
                n_tests++;
                if (mem_addr !== 32'h20) begin
                    n_fail++; $display("FAIL early_core_owner: addr=%h expected 00000020", mem_addr);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit exp_g;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            set_core(1, 0, 32'h20, 32'h0);
            set_ld(1, 0, 32'h10, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (core_stall !== 1'b0 || ld_rvalid !== 1'b0 || ld_rdata !== 32'h0 || ld_gnt !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: stall=%b rvalid=%b rdata=%h gnt=%b expected 0 0 0 0",
                               core_stall, ld_rvalid, ld_rdata, ld_gnt);
        end
        @(negedge clk);
        rst = 1'b0;
        set_core(0, 0, 32'h0, 32'h0);
        set_ld(0, 0, 32'h0, 32'h0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            set_core(1, 0, 32'h20, 32'h0);
            set_ld(1, 0, 32'h10, 32'h0);
            #1;
            exp_g = (c >= 8);
            n_tests++;
            if (ld_gnt !== exp_g || core_stall !== exp_g) begin
                n_fail++; $display("FAIL rst_rewait_c%0d: gnt=%b stall=%b expected %b %b", c, ld_gnt, core_stall, exp_g, exp_g);
            end
        end
    endtask

    task automatic test_write_safety();
        logic [31:0] a;
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = 32'($urandom_range(0, 255)) << 2;
            d = $urandom;
            set_core(0, 1, a, d);
            set_ld(0, 1, 32'h3FC - a, ~d);
            #1;
            n_tests++;
            if (mem_we !== 1'b0 || ld_gnt !== 1'b0 || mem_addr !== a || mem_wdata !== d) begin
                n_fail++; $display("FAIL write_safety_%0d: we=%b gnt=%b addr=%h wdata=%h expected 0 0 %h %h",
                                   i, mem_we, ld_gnt, mem_addr, mem_wdata, a, d);
            end
        end
    endtask

    // Random traffic obeying the hold rules, checked against the model.
    task automatic test_random();
        bit          e_gnt;
        bit          e_stall;
        bit          e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        bit          prev_stall;
        bit          prev_pending;
        int          ld_wait;
        int          stall_run;
        do_reset();
        prev_stall = 0; prev_pending = 0; ld_wait = 0; stall_run = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (!prev_stall)
                set_core($urandom_range(0, 99) < 75, 1'($urandom), 32'($urandom_range(0, 255)) << 2, $urandom);
            if (!prev_pending)
                set_ld($urandom_range(0, 99) < 50, 1'($urandom), 32'($urandom_range(0, 255)) << 2, $urandom);
            e_gnt   = m_burst ? ld_req : (ld_req && !core_req);
            e_stall = m_burst && ld_req && core_req;
            e_addr  = e_gnt ? ld_addr : core_addr;
            e_wdata = e_gnt ? ld_wdata : core_wdata;
            e_we    = e_gnt ? ld_we : (core_req && core_we);
            #1;
            n_tests++;
            if (ld_gnt !== e_gnt || core_stall !== e_stall) begin
                n_fail++; $display("FAIL rand_arb_c%0d: gnt=%b stall=%b expected %b %b", c, ld_gnt, core_stall, e_gnt, e_stall);
            end
            n_tests++;
            if (mem_we !== e_we || mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                n_fail++; $display("FAIL rand_port_c%0d: we=%b addr=%h wdata=%h expected %b %h %h",
                                   c, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wdata);
            end
            n_tests++;
            if (core_rdata !== m_mem[widx(e_addr)]) begin
                n_fail++; $display("FAIL rand_core_rdata_c%0d: rdata=%h expected %h", c, core_rdata, m_mem[widx(e_addr)]);
            end
            n_tests++;
            if (ld_rvalid !== m_rvalid || (m_rvalid && ld_rdata !== m_rdata)) begin
                n_fail++; $display("FAIL rand_ld_ret_c%0d: rvalid=%b rdata=%h expected %b %h", c, ld_rvalid, ld_rdata, m_rvalid, m_rdata);
            end
            ld_wait   = (ld_req && !ld_gnt) ? ld_wait + 1 : 0;
            stall_run = core_stall ? stall_run + 1 : 0;
            n_tests++;
            if (ld_wait > int'(MAX_WAIT) || stall_run > int'(BURST_LEN)) begin
                n_fail++; $display("FAIL rand_bound_c%0d: ld_wait=%0d stall_run=%0d limits %0d %0d",
                                   c, ld_wait, stall_run, MAX_WAIT, BURST_LEN);
            end
            // Model update for the edge that ends this cycle.
            m_rvalid = e_gnt && !ld_we;
            if (m_rvalid) m_rdata = m_mem[widx(ld_addr)];
            if (e_we) m_mem[widx(e_addr)] = e_wdata;
            if (m_burst) begin
                if (ld_req) m_beats++;
                if (!ld_req || m_beats == int'(BURST_LEN)) begin
                    m_burst = 0;
                    m_beats = 0;
                end
                m_denied = 0;
            end else if (ld_req && !e_gnt) begin
                m_denied++;
                if (m_denied == int'(MAX_WAIT)) begin
                    m_burst  = 1;
                    m_denied = 0;
                end
            end else begin
                m_denied = 0;
            end
            prev_stall   = e_stall;
            prev_pending = ld_req && !e_gnt;
        end
    endtask

    initial begin
        rst = 1'b1;
        set_core(0, 0, 32'h0, 32'h0);
        set_ld(0, 0, 32'h0, 32'h0);
        model_reset();
        test_reset();
        test_core_only();
        test_loader_idle();
        test_starvation();
        test_early_end();
        test_reset_mid_burst();
        test_write_safety();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
